// File: rtl/relay_stream_packer.sv
// relay_stream_packer
// Packs RATIO narrow words from a FIFO-style write port into one wide word
// and offers it to a relay station / FWFT FIFO write port (write/full_n).
// A 2-entry output queue decouples the packer from downstream backpressure.
// s_full_n, m_write, m_din and m_keep are all driven straight from registers.
//
// Optional feature: define RELAY_STREAM_PACKER_FLUSH_EN so that s_last on an
// accepted write closes a partial packet early. m_keep then marks the lanes
// that were written. With the macro undefined, s_last is ignored, every packet
// is exactly RATIO words long, and m_keep is always all-ones.

module relay_stream_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      s_full_n,
  input  logic                      s_write,
  input  logic [IN_WIDTH-1:0]       s_din,
  input  logic                      s_last,
  input  logic                      m_full_n,
  output logic                      m_write,
  output logic [IN_WIDTH*RATIO-1:0] m_din,
  output logic [RATIO-1:0]          m_keep,
  output logic [31:0]               word_count
);

  localparam int IDX_WIDTH = $clog2(RATIO);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

`ifdef RELAY_STREAM_PACKER_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  // Lanes 0..idx set: the lanes that hold data when a packet closes at idx.
  function automatic logic [RATIO-1:0] lane_mask(input logic [IDX_WIDTH-1:0] idx);
    logic [RATIO-1:0] mask;
    for (int k = 0; k < RATIO; k++) begin
      if (IDX_WIDTH'(k) <= idx) begin
        mask[k] = 1'b1;
      end else begin
        mask[k] = 1'b0;
      end
    end
    return mask;
  endfunction

  // Assembly state
  logic [IDX_WIDTH-1:0] idx_r;
  logic [OUT_WIDTH-1:0] asm_r;

  // Output queue; entry 0 is always the head
  logic [OUT_WIDTH-1:0] q_din_r  [2];
  logic [RATIO-1:0]     q_keep_r [2];
  logic [1:0]           oq_cnt_r;

  // Registered outputs
  logic                 m_write_r;
  logic                 s_full_n_r;
  logic [31:0]          word_count_r;

  // Combinational helpers
  logic                 in_acc_s;
  logic                 out_acc_s;
  logic                 idx_last_s;
  logic                 complete_s;
  logic [OUT_WIDTH-1:0] push_word_s;
  logic [RATIO-1:0]     push_keep_s;
  logic [1:0]           oq_cnt_nxt_s;

  // Handshake qualification and packet-completion decision
  always_comb begin
    in_acc_s   = s_write & s_full_n_r;
    out_acc_s  = m_write_r & m_full_n;
    idx_last_s = (idx_r == IDX_WIDTH'(RATIO - 1));
    complete_s = in_acc_s & (idx_last_s | (s_last & FLUSH_EN));
  end

  // Assembly word with the incoming narrow word merged into lane idx
  always_comb begin
    push_word_s = asm_r;
    for (int k = 0; k < RATIO; k++) begin
      if (idx_r == IDX_WIDTH'(k)) begin
        push_word_s[k*IN_WIDTH +: IN_WIDTH] = s_din;
      end else begin
        push_word_s[k*IN_WIDTH +: IN_WIDTH] = asm_r[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Lane-valid mask for the word being pushed
  always_comb begin
`ifdef RELAY_STREAM_PACKER_FLUSH_EN
    push_keep_s = lane_mask(idx_r);
`else
    push_keep_s = {RATIO{1'b1}};
`endif
  end

  // Next queue occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    case ({complete_s, out_acc_s})
      2'b10:   oq_cnt_nxt_s = oq_cnt_r + 2'd1;
      2'b01:   oq_cnt_nxt_s = oq_cnt_r - 2'd1;
      default: oq_cnt_nxt_s = oq_cnt_r;
    endcase
  end

  // Assembly register and lane index
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_r <= {IDX_WIDTH{1'b0}};
      asm_r <= {OUT_WIDTH{1'b0}};
    end else if (complete_s) begin
      idx_r <= {IDX_WIDTH{1'b0}};
      asm_r <= {OUT_WIDTH{1'b0}};
    end else if (in_acc_s) begin
      idx_r <= idx_r + IDX_WIDTH'(1);
      asm_r <= push_word_s;
    end else begin
      idx_r <= idx_r;
      asm_r <= asm_r;
    end
  end

  // Output queue storage: push at the tail, pop shifts entry 1 into the head
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_din_r[0]  <= {OUT_WIDTH{1'b0}};
      q_din_r[1]  <= {OUT_WIDTH{1'b0}};
      q_keep_r[0] <= {RATIO{1'b0}};
      q_keep_r[1] <= {RATIO{1'b0}};
    end else begin
      case ({complete_s, out_acc_s})
        2'b10: begin
          if (oq_cnt_r == 2'd0) begin
            q_din_r[0]  <= push_word_s;
            q_keep_r[0] <= push_keep_s;
          end else begin
            q_din_r[1]  <= push_word_s;
            q_keep_r[1] <= push_keep_s;
          end
        end
        2'b01: begin
          q_din_r[0]  <= q_din_r[1];
          q_keep_r[0] <= q_keep_r[1];
          q_din_r[1]  <= {OUT_WIDTH{1'b0}};
          q_keep_r[1] <= {RATIO{1'b0}};
        end
        2'b11: begin
          if (oq_cnt_r == 2'd1) begin
            q_din_r[0]  <= push_word_s;
            q_keep_r[0] <= push_keep_s;
          end else begin
            q_din_r[0]  <= q_din_r[1];
            q_keep_r[0] <= q_keep_r[1];
            q_din_r[1]  <= push_word_s;
            q_keep_r[1] <= push_keep_s;
          end
        end
        default: begin
          q_din_r[0]  <= q_din_r[0];
          q_din_r[1]  <= q_din_r[1];
          q_keep_r[0] <= q_keep_r[0];
          q_keep_r[1] <= q_keep_r[1];
        end
      endcase
    end
  end

  // Occupancy plus the flow-control flags decoded from next occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oq_cnt_r   <= 2'd0;
      m_write_r  <= 1'b0;
      s_full_n_r <= 1'b1;
    end else begin
      oq_cnt_r   <= oq_cnt_nxt_s;
      m_write_r  <= (oq_cnt_nxt_s != 2'd0);
      s_full_n_r <= (oq_cnt_nxt_s != 2'd2);
    end
  end

  // Count of wide words handed downstream, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_count_r <= 32'd0;
    end else if (out_acc_s) begin
      word_count_r <= word_count_r + 32'd1;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign s_full_n   = s_full_n_r;
  assign m_write    = m_write_r;
  assign m_din      = q_din_r[0];
  assign m_keep     = q_keep_r[0];
  assign word_count = word_count_r;

endmodule
